// File: rtl/output_port_allocator.sv
// rtl/output_port_allocator.sv - per-output-port round-robin allocator with packet hold and credit tracking
//
// Purpose:
//   Arbitrates round-robin among input units requesting this output port.
//   Holds the grant from the head flit to the tail flit.
//   Tracks downstream buffer credits and drives the crossbar select and the
//   per-flit send strobe.
//
// Ports:
//   clk, reset_n      clock, synchronous active-low reset
//   i_switch_req      per input: head flit wants this output
//   i_flit_valid      per input: flit presented this cycle
//   i_flit_tail       per input: presented flit is a tail
//   i_credit_return   downstream freed one buffer slot
//   o_grant           one-hot grant, held for the packet
//   o_sel             crossbar select (index of o_grant)
//   o_flit_send       granted flit transferred this cycle
//   o_port_busy       high while a packet owns the port
//   o_credits         current downstream credit count
//   o_credit_err      sticky credit overflow flag
//
// Optional feature (macro OUTPUT_ALLOC_STATS_EN):
//   o_pkt_count       tail sends, wrapping 16-bit counter
//   o_stall_cycles    credit-starved ACTIVE cycles, saturating 16-bit counter
module output_port_allocator #(
  parameter int NUM_OF_PORTS = 5,
  parameter int BUF_DEPTH    = 4,
  localparam int SEL_W  = (NUM_OF_PORTS > 1) ? $clog2(NUM_OF_PORTS) : 1,
  localparam int CRED_W = $clog2(BUF_DEPTH + 1)
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [NUM_OF_PORTS-1:0] i_switch_req,
  input  logic [NUM_OF_PORTS-1:0] i_flit_valid,
  input  logic [NUM_OF_PORTS-1:0] i_flit_tail,
  input  logic                    i_credit_return,
  output logic [NUM_OF_PORTS-1:0] o_grant,
  output logic [SEL_W-1:0]        o_sel,
  output logic                    o_flit_send,
  output logic                    o_port_busy,
  output logic [CRED_W-1:0]       o_credits,
  output logic                    o_credit_err
`ifdef OUTPUT_ALLOC_STATS_EN
  ,
  output logic [15:0]             o_pkt_count,
  output logic [15:0]             o_stall_cycles
`endif
);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t                  state, state_nxt;
  logic [SEL_W-1:0]        rr_ptr, rr_ptr_nxt;
  logic [NUM_OF_PORTS-1:0] grant_nxt;
  logic [SEL_W-1:0]        sel_nxt;
  logic [CRED_W-1:0]       credits_nxt;
  logic                    credit_err_nxt;
  logic                    pick_valid;
  logic [SEL_W-1:0]        pick_sel;
  logic [SEL_W:0]          scan_sum;
  logic [SEL_W-1:0]        scan_idx;
  logic                    tail_send;
  logic                    stall_cycle;

  // Round-robin search: first requester at or above rr_ptr, wrapping.
  // scan_sum is one bit wider so rr_ptr + offset cannot overflow before the wrap.
  always_comb begin
    pick_valid = 1'b0;
    pick_sel   = '0;
    scan_sum   = '0;
    scan_idx   = '0;
    for (int i = 0; i < NUM_OF_PORTS; i++) begin
      scan_sum = {1'b0, rr_ptr} + (SEL_W+1)'(i);
      if (scan_sum >= (SEL_W+1)'(NUM_OF_PORTS)) begin
        scan_sum = scan_sum - (SEL_W+1)'(NUM_OF_PORTS);
      end
      scan_idx = scan_sum[SEL_W-1:0];
      if (!pick_valid && i_switch_req[scan_idx]) begin
        pick_valid = 1'b1;
        pick_sel   = scan_idx;
      end
    end
  end

  assign o_port_busy = (state == ACTIVE);
  // A send needs a credit, so the counter can never underflow.
  assign o_flit_send = (state == ACTIVE) && i_flit_valid[o_sel] && (o_credits != '0);
  assign tail_send   = o_flit_send && i_flit_tail[o_sel];
  assign stall_cycle = (state == ACTIVE) && i_flit_valid[o_sel] && (o_credits == '0);

  always_comb begin
    state_nxt  = state;
    grant_nxt  = o_grant;
    sel_nxt    = o_sel;
    rr_ptr_nxt = rr_ptr;
    case (state)
      IDLE: begin
        if (pick_valid) begin
          state_nxt = ACTIVE;
          grant_nxt = NUM_OF_PORTS'(1) << pick_sel;
          sel_nxt   = pick_sel;
        end else begin
          grant_nxt = '0;
          sel_nxt   = '0;
        end
      end
      ACTIVE: begin
        // Requests are ignored here; only the tail send releases the port.
        if (tail_send) begin
          state_nxt  = IDLE;
          grant_nxt  = '0;
          sel_nxt    = '0;
          rr_ptr_nxt = (o_sel == SEL_W'(NUM_OF_PORTS - 1)) ? '0 : o_sel + SEL_W'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        grant_nxt = '0;
        sel_nxt   = '0;
      end
    endcase
  end

  // Send and return in the same cycle cancel out; a return at full credit
  // saturates and latches the error.
  always_comb begin
    credits_nxt    = o_credits;
    credit_err_nxt = o_credit_err;
    if (o_flit_send && !i_credit_return) begin
      credits_nxt = o_credits - CRED_W'(1);
    end else if (!o_flit_send && i_credit_return) begin
      if (o_credits == CRED_W'(BUF_DEPTH)) begin
        credit_err_nxt = 1'b1;
      end else begin
        credits_nxt = o_credits + CRED_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state        <= IDLE;
      rr_ptr       <= '0;
      o_grant      <= '0;
      o_sel        <= '0;
      o_credits    <= CRED_W'(BUF_DEPTH);
      o_credit_err <= 1'b0;
    end else begin
      state        <= state_nxt;
      rr_ptr       <= rr_ptr_nxt;
      o_grant      <= grant_nxt;
      o_sel        <= sel_nxt;
      o_credits    <= credits_nxt;
      o_credit_err <= credit_err_nxt;
    end
  end

`ifdef OUTPUT_ALLOC_STATS_EN
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      o_pkt_count    <= '0;
      o_stall_cycles <= '0;
    end else begin
      if (tail_send) begin
        o_pkt_count <= o_pkt_count + 16'd1;
      end
      if (stall_cycle && (o_stall_cycles != 16'hFFFF)) begin
        o_stall_cycles <= o_stall_cycles + 16'd1;
      end
    end
  end
`else
  logic unused_stats;
  assign unused_stats = stall_cycle;
`endif

endmodule

// File: tb/tb_output_port_allocator.sv
// tb/tb_output_port_allocator.sv - scoreboard bench for output_port_allocator
module tb_output_port_allocator;

  logic       clk;
  logic       reset_n;
  logic [4:0] switch_req;
  logic [4:0] flit_valid;
  logic [4:0] flit_tail;
  logic       credit_return;
  logic [4:0] grant;
  logic [2:0] sel;
  logic       flit_send;
  logic       port_busy;
  logic [2:0] credits;
  logic       credit_err;
`ifdef OUTPUT_ALLOC_STATS_EN
  logic [15:0] pkt_count;
  logic [15:0] stall_cycles;
`endif

  output_port_allocator #(.NUM_OF_PORTS(5), .BUF_DEPTH(4)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .i_switch_req    (switch_req),
    .i_flit_valid    (flit_valid),
    .i_flit_tail     (flit_tail),
    .i_credit_return (credit_return),
    .o_grant         (grant),
    .o_sel           (sel),
    .o_flit_send     (flit_send),
    .o_port_busy     (port_busy),
    .o_credits       (credits),
    .o_credit_err    (credit_err)
`ifdef OUTPUT_ALLOC_STATS_EN
    ,
    .o_pkt_count     (pkt_count),
    .o_stall_cycles  (stall_cycles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0] g;
    logic [2:0] s;
    logic       f;
    logic [2:0] c;
    logic       b;
    logic       e;
  } exp_t;

  typedef struct packed {
    logic       rn;
    logic [4:0] req;
    logic [4:0] v;
    logic [4:0] t;
    logic       cr;
    exp_t       x;
  } row_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic row_t mk(input logic rn, input logic [4:0] req, input logic [4:0] v,
                              input logic [4:0] t, input logic cr, input logic [4:0] g,
                              input logic [2:0] s, input logic f, input logic [2:0] c,
                              input logic b, input logic e);
    row_t r;
    r.rn = rn; r.req = req; r.v = v; r.t = t; r.cr = cr;
    r.x.g = g; r.x.s = s; r.x.f = f; r.x.c = c; r.x.b = b; r.x.e = e;
    return r;
  endfunction

  // Drive one cycle of stimulus just after the edge and queue what the
  // outputs must show before the next edge.
  task automatic drive(input row_t r);
    @(posedge clk); #1;
    reset_n       = r.rn;
    switch_req    = r.req;
    flit_valid    = r.v;
    flit_tail     = r.t;
    credit_return = r.cr;
    sb.push_back(r.x);
  endtask

  task automatic apply_reset();
    @(posedge clk); #1;
    reset_n = 1'b0; switch_req = '0; flit_valid = '0; flit_tail = '0; credit_return = 1'b0;
  endtask

  task automatic test_reset();
    row_t rows[$];
    exp_t ex, obs;
    rows.push_back(mk(1'b0, 5'h1F, 5'h1F, 5'h1F, 1'b1, 5'h00, 3'd0, 1'b0, 3'd4, 1'b0, 1'b0));
    rows.push_back(mk(1'b0, 5'h1F, 5'h1F, 5'h1F, 1'b1, 5'h00, 3'd0, 1'b0, 3'd4, 1'b0, 1'b0));
    rows.push_back(mk(1'b1, 5'h00, 5'h00, 5'h00, 1'b0, 5'h00, 3'd0, 1'b0, 3'd4, 1'b0, 1'b0));
    foreach (rows[k]) begin
      drive(rows[k]);
      @(negedge clk);
      ex  = sb.pop_front();
      obs = '{grant, sel, flit_send, credits, port_busy, credit_err};
      n_cmp++;
      if (obs !== ex) begin
        n_bad++;
        $display("FAIL reset[%0d] got %b want %b (grant,sel,send,cred,busy,err)", k, obs, ex);
      end
    end
  endtask

  task automatic test_single_flit();
    row_t rows[$];
    exp_t ex, obs;
    apply_reset();
    rows.push_back(mk(1'b1, 5'b00100, 5'b00100, 5'b00100, 1'b0, 5'b00000, 3'd0, 1'b0, 3'd4, 1'b0, 1'b0));
    rows.push_back(mk(1'b1, 5'b00000, 5'b00100, 5'b00100, 1'b0, 5'b00100, 3'd2, 1'b1, 3'd4, 1'b1, 1'b0));
    rows.push_back(mk(1'b1, 5'b00000, 5'b00000, 5'b00000, 1'b0, 5'b00000, 3'd0, 1'b0, 3'd3, 1'b0, 1'b0));
    foreach (rows[k]) begin
      drive(rows[k]);
      @(negedge clk);
      ex  = sb.pop_front();
      obs = '{grant, sel, flit_send, credits, port_busy, credit_err};
      n_cmp++;
      if (obs !== ex) begin
        n_bad++;
        $display("FAIL single_flit[%0d] got %b want %b (grant,sel,send,cred,busy,err)", k, obs, ex);
      end
    end
  endtask

  task automatic test_round_robin();
    row_t rows[$];
    exp_t ex, obs;
    logic [4:0] p;
    p = 5'b01001;
    apply_reset();
    rows.push_back(mk(1'b1, p, p, p, 1'b0, 5'b00000, 3'd0, 1'b0, 3'd4, 1'b0, 1'b0));
    rows.push_back(mk(1'b1, p, p, p, 1'b0, 5'b00001, 3'd0, 1'b1, 3'd4, 1'b1, 1'b0));
    rows.push_back(mk(1'b1, p, p, p, 1'b0, 5'b00000, 3'd0, 1'b0, 3'd3, 1'b0, 1'b0));
    rows.push_back(mk(1'b1, p, p, p, 1'b0, 5'b01000, 3'd3, 1'b1, 3'd3, 1'b1, 1'b0));
    rows.push_back(mk(1'b1, p, p, p, 1'b0, 5'b00000, 3'd0, 1'b0, 3'd2, 1'b0, 1'b0));
    rows.push_back(mk(1'b1, p, p, p, 1'b0, 5'b00001, 3'd0, 1'b1, 3'd2, 1'b1, 1'b0));
    rows.push_back(mk(1'b1, p, p, p, 1'b0, 5'b00000, 3'd0, 1'b0, 3'd1, 1'b0, 1'b0));
    rows.push_back(mk(1'b1, p, p, p, 1'b0, 5'b01000, 3'd3, 1'b1, 3'd1, 1'b1, 1'b0));
    foreach (rows[k]) begin
      drive(rows[k]);
      @(negedge clk);
      ex  = sb.pop_front();
      obs = '{grant, sel, flit_send, credits, port_busy, credit_err};
      n_cmp++;
      if (obs !== ex) begin
        n_bad++;
        $display("FAIL round_robin[%0d] got %b want %b (grant,sel,send,cred,busy,err)", k, obs, ex);
      end
      if (k == 2) begin
        n_cmp++;
        if (dut.rr_ptr !== 3'd1) begin
          n_bad++;
          $display("FAIL rr_ptr_after_port0 got %0d want 1", dut.rr_ptr);
        end
      end
    end
  endtask

  task automatic test_credit_stall();
    row_t rows[$];
    exp_t ex, obs;
    logic [4:0] p;
    p = 5'b00010;
    apply_reset();
    rows.push_back(mk(1'b1, p,     p, 5'd0, 1'b0, 5'd0, 3'd0, 1'b0, 3'd4, 1'b0, 1'b0));
    rows.push_back(mk(1'b1, 5'd0,  p, 5'd0, 1'b0, p,    3'd1, 1'b1, 3'd4, 1'b1, 1'b0));
    rows.push_back(mk(1'b1, 5'd0,  p, 5'd0, 1'b0, p,    3'd1, 1'b1, 3'd3, 1'b1, 1'b0));
    rows.push_back(mk(1'b1, 5'd0,  p, 5'd0, 1'b0, p,    3'd1, 1'b1, 3'd2, 1'b1, 1'b0));
    rows.push_back(mk(1'b1, 5'd0,  p, 5'd0, 1'b0, p,    3'd1, 1'b1, 3'd1, 1'b1, 1'b0));
    rows.push_back(mk(1'b1, 5'd0,  p, 5'd0, 1'b0, p,    3'd1, 1'b0, 3'd0, 1'b1, 1'b0));
    rows.push_back(mk(1'b1, 5'd0,  p, 5'd0, 1'b1, p,    3'd1, 1'b0, 3'd0, 1'b1, 1'b0));
    rows.push_back(mk(1'b1, 5'd0,  p, 5'd0, 1'b0, p,    3'd1, 1'b1, 3'd1, 1'b1, 1'b0));
    rows.push_back(mk(1'b1, 5'd0,  p, p,    1'b1, p,    3'd1, 1'b0, 3'd0, 1'b1, 1'b0));
    rows.push_back(mk(1'b1, 5'd0,  p, p,    1'b0, p,    3'd1, 1'b1, 3'd1, 1'b1, 1'b0));
    rows.push_back(mk(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0));
    foreach (rows[k]) begin
      drive(rows[k]);
      @(negedge clk);
      ex  = sb.pop_front();
      obs = '{grant, sel, flit_send, credits, port_busy, credit_err};
      n_cmp++;
      if (obs !== ex) begin
        n_bad++;
        $display("FAIL credit_stall[%0d] got %b want %b (grant,sel,send,cred,busy,err)", k, obs, ex);
      end
    end
`ifdef OUTPUT_ALLOC_STATS_EN
    n_cmp++;
    if (stall_cycles !== 16'd3 || pkt_count !== 16'd1) begin
      n_bad++;
      $display("FAIL stall_stats got stall=%0d pkts=%0d want stall=3 pkts=1", stall_cycles, pkt_count);
    end
`endif
  endtask

  task automatic test_simultaneous();
    row_t rows[$];
    exp_t ex, obs;
    logic [4:0] p;
    p = 5'b00001;
    apply_reset();
    rows.push_back(mk(1'b1, p,    p,    5'd0, 1'b0, 5'd0, 3'd0, 1'b0, 3'd4, 1'b0, 1'b0));
    rows.push_back(mk(1'b1, 5'd0, p,    5'd0, 1'b0, p,    3'd0, 1'b1, 3'd4, 1'b1, 1'b0));
    rows.push_back(mk(1'b1, 5'd0, p,    5'd0, 1'b0, p,    3'd0, 1'b1, 3'd3, 1'b1, 1'b0));
    rows.push_back(mk(1'b1, 5'd0, p,    p,    1'b1, p,    3'd0, 1'b1, 3'd2, 1'b1, 1'b0));
    rows.push_back(mk(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 3'd0, 1'b0, 3'd2, 1'b0, 1'b0));
    foreach (rows[k]) begin
      drive(rows[k]);
      @(negedge clk);
      ex  = sb.pop_front();
      obs = '{grant, sel, flit_send, credits, port_busy, credit_err};
      n_cmp++;
      if (obs !== ex) begin
        n_bad++;
        $display("FAIL simultaneous[%0d] got %b want %b (grant,sel,send,cred,busy,err)", k, obs, ex);
      end
    end
  endtask

  task automatic test_credit_overflow();
    row_t rows[$];
    exp_t ex, obs;
    rows.push_back(mk(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 5'd0, 3'd0, 1'b0, 3'd2, 1'b0, 1'b0));
    rows.push_back(mk(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 5'd0, 3'd0, 1'b0, 3'd3, 1'b0, 1'b0));
    rows.push_back(mk(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 5'd0, 3'd0, 1'b0, 3'd4, 1'b0, 1'b0));
    for (int i = 0; i < 11; i++) begin
      rows.push_back(mk(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 3'd0, 1'b0, 3'd4, 1'b0, 1'b1));
    end
    foreach (rows[k]) begin
      drive(rows[k]);
      @(negedge clk);
      ex  = sb.pop_front();
      obs = '{grant, sel, flit_send, credits, port_busy, credit_err};
      n_cmp++;
      if (obs !== ex) begin
        n_bad++;
        $display("FAIL credit_overflow[%0d] got %b want %b (grant,sel,send,cred,busy,err)", k, obs, ex);
      end
    end
  endtask

  task automatic test_reset_mid_packet();
    row_t rows[$];
    exp_t ex, obs;
    logic [4:0] p;
    p = 5'b10000;
`ifdef OUTPUT_ALLOC_STATS_EN
    n_cmp++;
    if (pkt_count !== 16'd1) begin
      n_bad++;
      $display("FAIL pkt_count_before_reset got %0d want 1", pkt_count);
    end
`endif
    rows.push_back(mk(1'b1, p,    p,    5'd0, 1'b0, 5'd0, 3'd0, 1'b0, 3'd4, 1'b0, 1'b1));
    rows.push_back(mk(1'b1, 5'd0, p,    5'd0, 1'b0, p,    3'd4, 1'b1, 3'd4, 1'b1, 1'b1));
    rows.push_back(mk(1'b1, 5'd0, p,    5'd0, 1'b0, p,    3'd4, 1'b1, 3'd3, 1'b1, 1'b1));
    rows.push_back(mk(1'b0, 5'd0, p,    5'd0, 1'b0, p,    3'd4, 1'b1, 3'd2, 1'b1, 1'b1));
    rows.push_back(mk(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 3'd0, 1'b0, 3'd4, 1'b0, 1'b0));
    foreach (rows[k]) begin
      drive(rows[k]);
      @(negedge clk);
      ex  = sb.pop_front();
      obs = '{grant, sel, flit_send, credits, port_busy, credit_err};
      n_cmp++;
      if (obs !== ex) begin
        n_bad++;
        $display("FAIL reset_mid_packet[%0d] got %b want %b (grant,sel,send,cred,busy,err)", k, obs, ex);
      end
    end
`ifdef OUTPUT_ALLOC_STATS_EN
    n_cmp++;
    if (pkt_count !== 16'd0 || stall_cycles !== 16'd0) begin
      n_bad++;
      $display("FAIL stats_after_reset got pkts=%0d stall=%0d want 0/0", pkt_count, stall_cycles);
    end
`endif
  endtask

  initial begin
    reset_n       = 1'b0;
    switch_req    = '0;
    flit_valid    = '0;
    flit_tail     = '0;
    credit_return = 1'b0;
    test_reset();
    test_single_flit();
    test_round_robin();
    test_credit_stall();
    test_simultaneous();
    test_credit_overflow();
    test_reset_mid_packet();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
